// File: rtl/keypad_scan_if.sv
// Keypad matrix pins plus the debounced key outputs of the scanner.
// No flow control: outputs are levels plus a one-cycle press pulse.
interface keypad_scan_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] playerB;
  logic       key_valid;
  logic       key_press;

  modport master (input row, output col, output playerB, output key_valid, output key_press);
  modport slave  (output row, input col, input playerB, input key_valid, input key_press);
endinterface

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner with whole-sweep debounce; sweep = 4*SETTLE_CYC+1 cycles.
// Accepted key appears the cycle after EVAL; no backpressure, consumer samples levels/pulse.
module keypad_scan #(
  parameter int SETTLE_CYC     = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic          clk,
  input  logic          rst,
  keypad_scan_if.master kp
);

  localparam int CW = $clog2(SETTLE_CYC);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_EVAL} state_t;

  // vld=0 encodes "no key", keeping key '0' distinct from idle
  typedef struct packed {
    logic       vld;
    logic [3:0] code;
  } key_t;

  state_t          state;
  logic [3:0]      row_s1;
  logic [3:0]      row_s2;
  logic [1:0]      col_idx;
  logic [CW-1:0]   settle_cnt;
  logic [15:0]     sweep_rows;
  logic [3:0]      col_q;
  logic            press_q;
  logic [DW-1:0]   db_cnt;
  logic [DW-1:0]   db_next;
  key_t            prev_key;
  key_t            acc_key;
  key_t            sweep_key;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // sweep_rows bit {col,row}; scan high to low so the lowest (col,row) wins
  always_comb begin
    sweep_key = '0;
    for (int i = 15; i >= 0; i--) begin
      if (sweep_rows[i]) begin
        sweep_key.vld  = 1'b1;
        sweep_key.code = key_code(2'(i % 4), 2'(i / 4));
      end
    end
  end

  always_comb begin
    db_next = DW'(1);
    if (sweep_key == prev_key)
      db_next = (db_cnt == DB_MAX) ? db_cnt : db_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      row_s1     <= 4'hF;
      row_s2     <= 4'hF;
      col_idx    <= 2'd0;
      settle_cnt <= '0;
      sweep_rows <= '0;
      col_q      <= 4'hF;
      press_q    <= 1'b0;
      db_cnt     <= '0;
      prev_key   <= '0;
      acc_key    <= '0;
    end else begin
      row_s1  <= kp.row;
      row_s2  <= row_s1;
      press_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          state      <= ST_SCAN;
          col_idx    <= 2'd0;
          settle_cnt <= '0;
          col_q      <= 4'b1110;
        end
        ST_SCAN: begin
          if (settle_cnt == CNT_LAST) begin
            sweep_rows[{col_idx, 2'b00} +: 4] <= ~row_s2;
            settle_cnt <= '0;
            if (col_idx == 2'd3) begin
              state <= ST_EVAL;
              col_q <= 4'hF;
            end else begin
              col_idx <= col_idx + 2'd1;
              col_q   <= ~(4'b0001 << (col_idx + 2'd1));
            end
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_EVAL: begin
          state   <= ST_SCAN;
          col_idx <= 2'd0;
          col_q   <= 4'b1110;
          db_cnt  <= db_next;
          if (sweep_key != prev_key)
            prev_key <= sweep_key;
          if (db_next == DB_MAX && sweep_key != acc_key) begin
            acc_key <= sweep_key;
            press_q <= sweep_key.vld;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign kp.col       = col_q;
  assign kp.playerB   = acc_key.code;
  assign kp.key_valid = acc_key.vld;
  assign kp.key_press = press_q;

endmodule
